// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/issue queue.
// Contents: RV32 opcode encodings, register-field extraction and the
// instruction classification used to decide which instructions may share an
// issue group.
package fetch_pkg;

    typedef enum logic [6:0] {
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_OP     = 7'b0110011,
        OP_IMM    = 7'b0010011
    } opcode_e;

    typedef logic [4:0] reg_idx_t;

    function automatic logic [6:0] opcode(input logic [31:0] ins);
        return ins[6:0];
    endfunction

    function automatic reg_idx_t rd(input logic [31:0] ins);
        return ins[11:7];
    endfunction

    function automatic reg_idx_t rs1(input logic [31:0] ins);
        return ins[19:15];
    endfunction

    function automatic reg_idx_t rs2(input logic [31:0] ins);
        return ins[24:20];
    endfunction

    // A write to x0 is architecturally invisible, so it never creates a hazard.
    function automatic logic writes_rd(input logic [31:0] ins);
        logic cls;
        case (opcode(ins))
            OP_JAL, OP_JALR, OP_LUI, OP_OP, OP_IMM: cls = 1'b1;
            default:                                cls = 1'b0;
        endcase
        return cls && (rd(ins) != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ins);
        case (opcode(ins))
            OP_BRANCH, OP_JALR, OP_OP, OP_IMM: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        case (opcode(ins))
            OP_BRANCH, OP_OP: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_ctrl(input logic [31:0] ins);
        case (opcode(ins))
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Bundle interface between instruction fetch, the issue queue and the issue
// lanes.
//   fetch_*     : bundle from fetch (slot 0 in MSBs), fetch_ready back-pressure
//   issue_*     : presented issue group (slot 0 in MSBs), issue_stall from lanes
//   flush       : redirect, discard queue contents
//   occupancy   : instructions currently held
// Modports: master = fetch/issue environment, slave = the queue.
interface fetch_issue_queue_if #(
    parameter int ISSUE_W = 2,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 12,
    parameter int DEPTH   = 8
);
    logic                          fetch_valid;
    logic                          fetch_ready;
    logic [ISSUE_W*INSTR_W-1:0]    fetch_data;
    logic [ISSUE_W-1:0]            fetch_mask;
    logic [PC_W-1:0]               fetch_pc;
    logic [ISSUE_W-1:0]            issue_valid;
    logic [ISSUE_W*INSTR_W-1:0]    issue_instr;
    logic [ISSUE_W*PC_W-1:0]       issue_pc;
    logic                          issue_stall;
    logic                          flush;
    logic [$clog2(DEPTH+1)-1:0]    occupancy;

    modport master (
        output fetch_valid, fetch_data, fetch_mask, fetch_pc, issue_stall, flush,
        input  fetch_ready, issue_valid, issue_instr, issue_pc, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_data, fetch_mask, fetch_pc, issue_stall, flush,
        output fetch_ready, issue_valid, issue_instr, issue_pc, occupancy
    );
endinterface

// File: rtl/issue_dep_check.sv
// Pairwise hazard check between an older and a younger instruction of a
// candidate issue group.
//   older, younger : raw 32-bit instructions
//   conflict       : younger reads or rewrites a register the older one writes
module issue_dep_check
    import fetch_pkg::*;
(
    input  logic [31:0] older,
    input  logic [31:0] younger,
    output logic        conflict
);
    reg_idx_t dst;

    always_comb begin
        dst      = rd(older);
        conflict = 1'b0;
        if (writes_rd(older)) begin
            if (uses_rs1(younger) && (rs1(younger) == dst)) conflict = 1'b1;
            if (uses_rs2(younger) && (rs2(younger) == dst)) conflict = 1'b1;
            if (writes_rd(younger) && (rd(younger) == dst)) conflict = 1'b1;
        end
    end

    // Immediate/funct fields play no part in the hazard decision.
    logic unused_fields;
    assign unused_fields = ^{older, younger};

endmodule

// File: rtl/fetch_issue_queue.sv
// N-wide instruction queue between wide fetch and the parallel issue lanes.
// Buffers fetch bundles per instruction in a circular buffer and presents the
// oldest hazard-free group each cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_issue_queue_if.slave (fetch bundle in, issue group out,
//              issue_stall, flush, occupancy)
module fetch_issue_queue
    import fetch_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 12,
    parameter int PC_STEP = 4
) (
    input logic clk,
    input logic rst,
    fetch_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    logic [AW-1:0]      head, tail;
    logic [CW-1:0]      count;

    // Head window and group formation
    logic [INSTR_W-1:0] hd_instr [ISSUE_W];
    logic [PC_W-1:0]    hd_pc    [ISSUE_W];
    logic               ctrl     [ISSUE_W];
    logic               conf     [ISSUE_W][ISSUE_W];
    logic [ISSUE_W-1:0] grp_v;      // bit j = slot j
    logic               chain_ok;

    // Enqueue staging, per original fetch slot
    logic               slot_v     [ISSUE_W];
    logic [AW-1:0]      slot_ptr   [ISSUE_W];
    logic [INSTR_W-1:0] slot_instr [ISSUE_W];
    logic [PC_W-1:0]    slot_pc    [ISSUE_W];

    logic               enq, deq, ready;
    logic [CW-1:0]      enq_n, deq_n, enq_add, deq_sub;
    logic [ISSUE_W-1:0]         issue_valid_w;
    logic [ISSUE_W*INSTR_W-1:0] issue_instr_w;
    logic [ISSUE_W*PC_W-1:0]    issue_pc_w;

    always_comb begin
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            hd_instr[j] = instr_q[head + AW'(j)];
            hd_pc[j]    = pc_q[head + AW'(j)];
            ctrl[j]     = is_ctrl(hd_instr[j][31:0]);
        end
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_old
        for (genvar j = 0; j < ISSUE_W; j++) begin : g_young
            if (i < j) begin : g_chk
                issue_dep_check u_chk (
                    .older    (hd_instr[i][31:0]),
                    .younger  (hd_instr[j][31:0]),
                    .conflict (conf[i][j])
                );
            end else begin : g_none
                assign conf[i][j] = 1'b0;
            end
        end
    end

    // Each slot extends the group only if every older slot in it is neither
    // control flow nor a producer the slot depends on.
    always_comb begin
        grp_v    = '0;
        chain_ok = 1'b0;
        grp_v[0] = !rst && (count != '0);
        for (int unsigned j = 1; j < ISSUE_W; j++) begin
            chain_ok = grp_v[j-1] && (int'(count) > int'(j));
            for (int unsigned i = 0; i < j; i++) begin
                if (ctrl[i] || conf[i][j]) chain_ok = 1'b0;
            end
            grp_v[j] = chain_ok;
        end
    end

    always_comb begin
        issue_valid_w = '0;
        issue_instr_w = '0;
        issue_pc_w    = '0;
        deq_n         = '0;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            issue_valid_w[ISSUE_W-1-j] = grp_v[j];
            if (grp_v[j]) begin
                issue_instr_w[(ISSUE_W-1-j)*INSTR_W +: INSTR_W] = hd_instr[j];
                issue_pc_w[(ISSUE_W-1-j)*PC_W +: PC_W]          = hd_pc[j];
            end
            deq_n = deq_n + CW'(grp_v[j]);
        end
    end

    // Masked slots are packed contiguously at tail; PC still follows the
    // original slot position.
    always_comb begin
        enq_n = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            slot_v[k]     = bus.fetch_mask[ISSUE_W-1-k];
            slot_ptr[k]   = tail + AW'(enq_n);
            slot_instr[k] = bus.fetch_data[(ISSUE_W-1-k)*INSTR_W +: INSTR_W];
            slot_pc[k]    = bus.fetch_pc + PC_W'(k * PC_STEP);
            enq_n         = enq_n + CW'(slot_v[k]);
        end
    end

    always_comb begin
        ready   = !rst && ((DEPTH - int'(count)) >= ISSUE_W);
        enq     = bus.fetch_valid && ready && !bus.flush;
        deq     = (|grp_v) && !bus.issue_stall && !bus.flush;
        enq_add = enq ? enq_n : '0;
        deq_sub = deq ? deq_n : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                instr_q[e] <= '0;
                pc_q[e]    <= '0;
            end
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                for (int unsigned k = 0; k < ISSUE_W; k++) begin
                    if (slot_v[k]) begin
                        instr_q[slot_ptr[k]] <= slot_instr[k];
                        pc_q[slot_ptr[k]]    <= slot_pc[k];
                    end
                end
                tail <= tail + AW'(enq_n);
            end
            if (deq) head <= head + AW'(deq_n);
            count <= count + enq_add - deq_sub;
        end
    end

    assign bus.fetch_ready = ready;
    assign bus.issue_valid = issue_valid_w;
    assign bus.issue_instr = issue_instr_w;
    assign bus.issue_pc    = issue_pc_w;
    assign bus.occupancy   = rst ? '0 : count;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue (ISSUE_W=2, DEPTH=8, PC_W=12).
module tb_fetch_issue_queue;
    localparam int ISSUE_W = 2;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 8;
    localparam int PC_W    = 12;
    localparam int PC_STEP = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_issue_queue_if #(.ISSUE_W(ISSUE_W), .INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    fetch_issue_queue #(
        .ISSUE_W(ISSUE_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_W(PC_W), .PC_STEP(PC_STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] m, input logic [11:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = {i0, i1};
        bus.fetch_mask  = m;
        bus.fetch_pc    = pc;
        step();
        bus.fetch_valid = 1'b0;
        bus.fetch_mask  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fetch_valid = 1'b1; bus.fetch_data = '1; bus.fetch_mask = 2'b11;
        bus.fetch_pc = 12'h0; bus.issue_stall = 1'b0; bus.flush = 1'b0;
        step(); step();
        n_checks++;
        if ({bus.fetch_ready, bus.issue_valid, bus.occupancy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_held: got rdy=%b v=%b occ=%0d need 0/00/0",
                     bus.fetch_ready, bus.issue_valid, bus.occupancy);
        end
        bus.fetch_valid = 1'b0; bus.fetch_mask = '0;
        rst = 1'b0;
        step();
        n_checks++;
        if ({bus.fetch_ready, bus.issue_valid, bus.occupancy} !== {1'b1, 2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b occ=%0d need 1/00/0",
                     bus.fetch_ready, bus.issue_valid, bus.occupancy);
        end
    endtask

    task automatic test_basic();
        push(addi(5'd1, 12'd5), addi(5'd2, 12'd7), 2'b11, 12'h010);
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy} !==
            {2'b11, 32'h00500093, 32'h00700113, 12'h010, 12'h014, 4'd2}) begin
            n_fail++;
            $display("FAIL basic_group: got v=%b i=%h pc=%h occ=%0d need 11/0050009300700113/010014/2",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy);
        end
        step();
        n_checks++;
        if ({bus.issue_valid, bus.occupancy} !== {2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%b occ=%0d need 00/0", bus.issue_valid, bus.occupancy);
        end
    endtask

    task automatic test_dependency();
        push(32'h00100093, 32'h001081B3, 2'b11, 12'h020);   // addi x1,x0,1 ; add x3,x1,x1
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy} !==
            {2'b10, 32'h00100093, 32'h0, 12'h020, 12'h000, 4'd2}) begin
            n_fail++;
            $display("FAIL raw_first: got v=%b i=%h pc=%h occ=%0d need 10/0010009300000000/020000/2",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy);
        end
        step();
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy} !==
            {2'b10, 32'h001081B3, 32'h0, 12'h024, 12'h000, 4'd1}) begin
            n_fail++;
            $display("FAIL raw_second: got v=%b i=%h pc=%h occ=%0d need 10/001081b300000000/024000/1",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy);
        end
        step();
        push(32'h00100013, 32'h00200013, 2'b11, 12'h030);   // addi x0,x0,1 ; addi x0,x0,2
        n_checks++;
        if ({bus.issue_valid, bus.occupancy} !== {2'b11, 4'd2}) begin
            n_fail++;
            $display("FAIL x0_pair: got v=%b occ=%0d need 11/2", bus.issue_valid, bus.occupancy);
        end
        step();
    endtask

    task automatic test_control();
        push(32'h00208463, 32'h00100293, 2'b11, 12'h040);   // beq x1,x2,8 ; addi x5,x0,1
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc} !==
            {2'b10, 32'h00208463, 32'h0, 12'h040, 12'h000}) begin
            n_fail++;
            $display("FAIL branch_alone: got v=%b i=%h pc=%h need 10/0020846300000000/040000",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc);
        end
        step();
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc} !==
            {2'b10, 32'h00100293, 32'h0, 12'h044, 12'h000}) begin
            n_fail++;
            $display("FAIL branch_next: got v=%b i=%h pc=%h need 10/0010029300000000/044000",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc);
        end
        step();
    endtask

    task automatic test_mask();
        push(32'hFFFFFFFF, addi(5'd7, 12'd3), 2'b01, 12'h200);
        n_checks++;
        if ({bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy} !==
            {2'b10, 32'h00300393, 32'h0, 12'h204, 12'h000, 4'd1}) begin
            n_fail++;
            $display("FAIL mask_01: got v=%b i=%h pc=%h occ=%0d need 10/0030039300000000/204000/1",
                     bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.occupancy);
        end
        step();
        push(32'h00100093, 32'h00200113, 2'b00, 12'h300);
        n_checks++;
        if ({bus.issue_valid, bus.occupancy} !== {2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL mask_00: got v=%b occ=%0d need 00/0", bus.issue_valid, bus.occupancy);
        end
    endtask

    task automatic test_fill();
        bus.issue_stall = 1'b1;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (bus.fetch_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready_%0d: got %b need 1", b, bus.fetch_ready);
            end
            push(addi(5'(2*b+1), 12'(16*b)), addi(5'(2*b+2), 12'(16*b+1)), 2'b11, 12'(12'h100 + 8*b));
            n_checks++;
            if (bus.occupancy !== 4'(2*b+2)) begin
                n_fail++;
                $display("FAIL fill_occ_%0d: got %0d need %0d", b, bus.occupancy, 2*b+2);
            end
        end
        n_checks++;
        if ({bus.fetch_ready, bus.issue_valid, bus.issue_pc} !== {1'b0, 2'b11, 12'h100, 12'h104}) begin
            n_fail++;
            $display("FAIL fill_full: got rdy=%b v=%b pc=%h need 0/11/100104",
                     bus.fetch_ready, bus.issue_valid, bus.issue_pc);
        end
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = {addi(5'd9, 12'd64), addi(5'd10, 12'd65)};
        bus.fetch_mask  = 2'b11;
        bus.fetch_pc    = 12'h120;
        step();
        n_checks++;
        if ({bus.fetch_ready, bus.occupancy} !== {1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL fill_hold: got rdy=%b occ=%0d need 0/8", bus.fetch_ready, bus.occupancy);
        end
        bus.issue_stall = 1'b0;
        step();
        n_checks++;
        if ({bus.fetch_ready, bus.occupancy} !== {1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL fill_release: got rdy=%b occ=%0d need 1/6", bus.fetch_ready, bus.occupancy);
        end
        step();
        n_checks++;
        if ({bus.occupancy, bus.issue_pc} !== {4'd6, 12'h110, 12'h114}) begin
            n_fail++;
            $display("FAIL fill_enq_deq: got occ=%0d pc=%h need 6/110114", bus.occupancy, bus.issue_pc);
        end
        bus.fetch_valid = 1'b0;
        bus.issue_stall = 1'b1;
    endtask

    task automatic test_flush();
        bus.flush       = 1'b1;
        bus.issue_stall = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_data  = {addi(5'd11, 12'd1), addi(5'd12, 12'd2)};
        bus.fetch_mask  = 2'b11;
        bus.fetch_pc    = 12'h500;
        #1;
        n_checks++;
        if ({bus.issue_valid, bus.issue_pc} !== {2'b11, 12'h110, 12'h114}) begin
            n_fail++;
            $display("FAIL flush_cycle: got v=%b pc=%h need 11/110114", bus.issue_valid, bus.issue_pc);
        end
        step();
        bus.flush = 1'b0;
        bus.fetch_valid = 1'b0;
        n_checks++;
        if ({bus.fetch_ready, bus.issue_valid, bus.occupancy} !== {1'b1, 2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL flush_after: got rdy=%b v=%b occ=%0d need 1/00/0",
                     bus.fetch_ready, bus.issue_valid, bus.occupancy);
        end
        step();
        n_checks++;
        if ({bus.issue_valid, bus.occupancy} !== {2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL flush_dropped: got v=%b occ=%0d need 00/0", bus.issue_valid, bus.occupancy);
        end
    endtask

    task automatic test_stream();
        logic [43:0] gold[$];
        logic [43:0] exp_e;
        logic [31:0] i0, i1, got_i;
        logic [11:0] pc, got_pc;
        logic [1:0]  m;
        int bidx = 0;
        int cyc  = 0;
        while ((bidx < 20 || gold.size() != 0) && cyc < 400) begin
            bus.issue_stall = ($urandom_range(0, 2) == 0);
            if (!bus.issue_stall) begin
                for (int j = 0; j < 2; j++) begin
                    if (bus.issue_valid[1-j]) begin
                        got_i  = bus.issue_instr[(1-j)*32 +: 32];
                        got_pc = bus.issue_pc[(1-j)*12 +: 12];
                        n_checks++;
                        if (gold.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_extra: got %h@%h need nothing", got_i, got_pc);
                        end else begin
                            exp_e = gold.pop_front();
                            if ({got_i, got_pc} !== exp_e) begin
                                n_fail++;
                                $display("FAIL stream_order: got %h@%h need %h@%h",
                                         got_i, got_pc, exp_e[43:12], exp_e[11:0]);
                            end
                        end
                    end
                end
            end
            if (bidx < 20) begin
                i0 = addi(5'd1, 12'(2*bidx));
                i1 = addi((bidx % 3 == 0) ? 5'd1 : 5'd2, 12'(2*bidx+1));
                m  = (bidx == 5) ? 2'b01 : (bidx == 9) ? 2'b10 : (bidx == 13) ? 2'b00 : 2'b11;
                pc = 12'hFE0 + 12'(8*bidx);
                bus.fetch_valid = 1'b1;
                bus.fetch_data  = {i0, i1};
                bus.fetch_mask  = m;
                bus.fetch_pc    = pc;
                if (bus.fetch_ready) begin
                    if (m[1]) gold.push_back({i0, pc});
                    if (m[0]) gold.push_back({i1, pc + 12'd4});
                    bidx++;
                end
            end else begin
                bus.fetch_valid = 1'b0;
                bus.fetch_mask  = '0;
            end
            step();
            cyc++;
        end
        bus.fetch_valid = 1'b0;
        bus.issue_stall = 1'b0;
        n_checks++;
        if (cyc >= 400) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d bundles, %0d pending, need 20/0", bidx, gold.size());
        end else if ({bus.issue_valid, bus.occupancy} !== {2'b00, 4'd0}) begin
            n_fail++;
            $display("FAIL stream_empty: got v=%b occ=%0d need 00/0", bus.issue_valid, bus.occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dependency();
        test_control();
        test_mask();
        test_fill();
        test_flush();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
Parametrised N-wide instruction queue between the wide instruction-RAM fetch and the parallel control/ALU/regfile lanes of the multi-issue CPU. It accepts fetch bundles of ISSUE_W instructions, buffers them per instruction, and presents the oldest group each cycle. A group stops at the first intra-group data dependency or after a control-flow instruction, so dependent pairs are never co-issued. Redirects flush all buffered state in one cycle.

Parameters:
ISSUE_W, 2, instructions per fetch bundle and maximum issue group size (power of 2, ≥1)
INSTR_W, 32, instruction width
DEPTH, 8, queue capacity in instructions (power of 2, ≥2*ISSUE_W)
PC_W, 12, PC width
PC_STEP, 4, PC increment between consecutive instructions in a bundle

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fetch_valid  in  1  bundle present
fetch_ready  out  1  queue accepts a full bundle this cycle
fetch_data  in  ISSUE_W*INSTR_W  bundle; slot 0 in MSBs (oldest)
fetch_mask  in  ISSUE_W  per-slot valid; bit ISSUE_W-1 = slot 0
fetch_pc  in  PC_W  PC of slot 0
issue_valid  out  ISSUE_W  per-slot valid, contiguous from slot 0
issue_instr  out  ISSUE_W*INSTR_W  group instructions, slot 0 in MSBs
issue_pc  out  ISSUE_W*PC_W  per-slot PC
issue_stall  in  1  downstream refuses the group this cycle
flush  in  1  redirect: discard all contents
occupancy  out  $clog2(DEPTH+1)  instructions held

Behaviour:
- Storage: circular buffer of DEPTH entries {instr, pc}, head/tail pointers wrap modulo DEPTH, separate count register.
- Reset (rst high at posedge): head=tail=count=0; all entries' instr cleared to 0. While rst is high: fetch_ready=0, issue_valid=0, occupancy=0. fetch_ready may rise the cycle after rst deasserts.
- fetch_ready = (DEPTH - count ≥ ISSUE_W) && !rst; computed from the current count only (a same-cycle dequeue gives no credit).
- Enqueue when fetch_valid && fetch_ready && !flush: masked slots are written compacted in slot order at tail; entry pc = fetch_pc + k*PC_STEP, where k is the original slot index, truncated to PC_W. Tail advances by popcount(fetch_mask). fetch_mask = 0 is a legal no-op. Non-contiguous masks are legal.
- Latency: an enqueued instruction is visible on issue outputs the next cycle at the earliest (no bypass).
- Group formation (combinational from head entries): slot 0 valid iff count ≥ 1. Slot j>0 valid iff:
  - slot j-1 is valid;
  - count > j;
  - no older slot i<j in the group is a branch/jal/jalr;
  - for every older slot i that writes rd (rd ≠ x0), rd[i] ≠ rs1[j], rd[i] ≠ rs2[j] (only for source fields the younger opcode uses), and rd[i] ≠ rd[j] when j also writes.
- Dequeue when any issue_valid && !issue_stall && !flush: the whole presented group is consumed; head advances by popcount(issue_valid).
- Counts: count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue are both honoured. Count never exceeds DEPTH; overflow is impossible by the fetch_ready rule.
- flush has priority over everything: head=tail=count=0 next cycle, the same-cycle bundle is dropped, and issue_valid is still driven from the old contents during the flush cycle but is not consumed. The next cycle shows issue_valid=0.
- issue_instr/issue_pc for invalid slots are 0.
- Wrap-around: a group may span entries DEPTH-1 and 0; ordering is preserved.

Decomposition:
- Package fetch_pkg: opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_LUI 7'b0110111, OP_OP 7'b0110011, OP_IMM 7'b0010011), field-extraction functions (rd, rs1, rs2), and classification functions writes_rd, uses_rs1, uses_rs2, is_ctrl.
- One sub-module, issue_dep_check: a combinational older/younger pair checker returning a conflict flag. It is instantiated for every (i,j) pair with i<j and feeds the valid-chain logic.

Test Plan:
- Reset then fetch_valid=1, mask=2'b11, instrs {addi x1,x0,5; addi x2,x0,7}, pc=0x010 → next cycle issue_valid=2'b11, issue_pc={0x010,0x014}, occupancy=2; cycle after (no stall): occupancy=0.
- Bundle {addi x1,x0,1; add x3,x1,x1} → issue_valid=2'b10 first cycle, then slot 0 = add with pc+4 the next cycle; with younger rd=x0 writer and older rd=x0, both issue.
- Bundle {beq x1,x2,8; addi x5,x0,1} → beq issues alone; addi issues the following cycle.
- Fill with issue_stall=1 and 4 full bundles: fetch_ready drops when occupancy=7? No: it drops at occupancy=8 (DEPTH=8, needs 2 free), i.e. after 4 bundles; a bundle offered then is not accepted and is held by the fetch side.
- With occupancy=6, assert flush together with fetch_valid → next cycle occupancy=0, issue_valid=0, the new bundle is absent.
- Run 20 bundles with random issue_stall through pointer wrap → in-order issue stream matches the golden list, PCs correct across the wrap; mask=2'b01 bundle enqueues only slot 1 with pc=fetch_pc+4.
